// File: rtl/code_decoder_pulse_pkg.sv
// Shared types and defaults for code_decoder_pulse.
//   state_t     : FSM state encoding (2'd3 unused, recovers to IDLE)
//   CODE_W/Y_W  : code and one-hot output widths
//   DEF_*       : default hold/gap cycle counts and counter width
//   onehot()    : 3-bit code to 8-bit one-hot line
package code_decoder_pkg;

  localparam int unsigned CODE_W    = 3;
  localparam int unsigned Y_W       = 8;
  localparam int unsigned DEF_HOLD  = 4;
  localparam int unsigned DEF_GAP   = 1;
  localparam int unsigned DEF_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  function automatic logic [Y_W-1:0] onehot(input logic [CODE_W-1:0] c);
    return Y_W'(1) << c;
  endfunction

endpackage

// File: rtl/code_decoder_pulse_if.sv
// Code handshake and decoded-strobe bundle for code_decoder_pulse.
//   master : upstream driver (en, code, code_valid) observing ready/y/status
//   slave  : the decoder itself
interface code_decoder_pulse_if;
  import code_decoder_pkg::*;

  logic              en;
  logic [CODE_W-1:0] code;
  logic              code_valid;
  logic              code_ready;
  logic [Y_W-1:0]    y;
  logic              y_valid;
  logic              busy;

  modport master (
    output en, code, code_valid,
    input  code_ready, y, y_valid, busy
  );

  modport slave (
    input  en, code, code_valid,
    output code_ready, y, y_valid, busy
  );
endinterface

// File: rtl/code_decoder_pulse_load_down_counter.sv
// Loadable down counter with a zero flag; shared by the hold and gap phases.
//   clk, rst : clock, async active-high reset
//   clr      : synchronous clear to zero (highest priority)
//   load     : load load_val
//   dec      : decrement by one (ignored at zero)
//   cnt      : current count
//   zero     : cnt == 0
module load_down_counter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/code_decoder_pulse.sv
// Accepts a 3-bit code over valid/ready and holds the matching one-hot line
// for HOLD_CYCLES, then idles GAP_CYCLES before accepting again.
//   clk, rst : clock, async active-high reset
//   bus      : slave side of code_decoder_pulse_if
//              en (abort/enable), code, code_valid -> code_ready (comb),
//              y (registered one-hot), y_valid, busy
module code_decoder_pulse
  import code_decoder_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = DEF_HOLD,
  parameter int unsigned GAP_CYCLES  = DEF_GAP,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic            clk,
  input  logic            rst,
  code_decoder_pulse_if.slave bus
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

  state_t         state, state_n;
  logic [Y_W-1:0] y_q, y_n;
  logic           y_valid_q, busy_q;
  logic           accept;
  logic           cnt_clr, cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_load_val;
  logic [CNT_W-1:0] cnt;

  assign bus.code_ready = bus.en && (state == ST_IDLE);
  assign accept         = bus.code_valid && bus.code_ready;

  load_down_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  // State, one-hot and status registers; status tracks the next state so it
  // lines up with y.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_n;
      y_q       <= y_n;
      y_valid_q <= (state_n == ST_HOLD);
      busy_q    <= (state_n != ST_IDLE);
    end
  end

  // Next-state, next-y and counter control.
  always_comb begin
    state_n      = state;
    y_n          = y_q;
    cnt_clr      = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;

    if (!bus.en) begin
      state_n = ST_IDLE;
      y_n     = '0;
      cnt_clr = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            y_n          = onehot(bus.code);
            cnt_load     = 1'b1;
            cnt_load_val = HOLD_LOAD;
            state_n      = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (cnt_zero) begin
            y_n = '0;
            if (GAP_CYCLES == 0) begin
              state_n = ST_IDLE;
            end else begin
              cnt_load     = 1'b1;
              cnt_load_val = GAP_LOAD;
              state_n      = ST_GAP;
            end
          end else begin
            cnt_dec = 1'b1;
          end
        end
        ST_GAP: begin
          if (cnt_zero) begin
            state_n = ST_IDLE;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        default: begin
          state_n = ST_IDLE;
          y_n     = '0;
          cnt_clr = 1'b1;
        end
      endcase
    end
  end

  assign bus.y       = y_q;
  assign bus.y_valid = y_valid_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_code_decoder_pulse.sv
// Directed bench: DUT a uses HOLD=4/GAP=1, DUT b uses HOLD=1/GAP=0.
module tb_code_decoder_pulse;
  import code_decoder_pkg::*;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  code_decoder_pulse_if a_if ();
  code_decoder_pulse_if b_if ();

  code_decoder_pulse #(.HOLD_CYCLES(4), .GAP_CYCLES(1), .CNT_W(4)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if)
  );

  code_decoder_pulse #(.HOLD_CYCLES(1), .GAP_CYCLES(0), .CNT_W(4)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] b2b_y  [3];
    logic [2:0] b2b_c  [3];
    logic [7:0] walk_y [8];
    n_cmp = 0;
    n_err = 0;
    b2b_c  = '{3'd0, 3'd7, 3'd2};
    b2b_y  = '{8'h01, 8'h80, 8'h04};
    walk_y = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

    rst = 1'b1;
    a_if.en = 1'b1; a_if.code = 3'd0; a_if.code_valid = 1'b0;
    b_if.en = 1'b0; b_if.code = 3'd0; b_if.code_valid = 1'b0;
    #2;
    chk("rst_ready_en", 32'(a_if.code_ready), 32'd1);
    step(); step();
    rst = 1'b0;
    step();
    chk("idle_y", 32'(a_if.y), 32'h00);
    chk("idle_yv", 32'(a_if.y_valid), 32'd0);
    chk("idle_busy", 32'(a_if.busy), 32'd0);
    chk("idle_ready", 32'(a_if.code_ready), 32'd1);

    // Single decode of code 5; code changes during hold must not matter.
    a_if.code = 3'd5; a_if.code_valid = 1'b1;
    step();
    a_if.code_valid = 1'b0; a_if.code = 3'd1;
    chk("single_y0", 32'(a_if.y), 32'h20);
    chk("single_yv", 32'(a_if.y_valid), 32'd1);
    chk("single_busy", 32'(a_if.busy), 32'd1);
    chk("single_rdy", 32'(a_if.code_ready), 32'd0);
    for (int i = 1; i < 4; i++) begin
      step();
      chk("single_hold", 32'(a_if.y), 32'h20);
    end
    step();
    chk("single_gap_y", 32'(a_if.y), 32'h00);
    chk("single_gap_yv", 32'(a_if.y_valid), 32'd0);
    chk("single_gap_busy", 32'(a_if.busy), 32'd1);
    chk("single_gap_rdy", 32'(a_if.code_ready), 32'd0);
    step();
    chk("single_end_busy", 32'(a_if.busy), 32'd0);
    chk("single_end_rdy", 32'(a_if.code_ready), 32'd1);

    // Back-to-back 0,7,2 with valid held: one accept every 6 cycles.
    a_if.code_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a_if.code = b2b_c[k];
      step();
      chk("b2b_y", 32'(a_if.y), 32'(b2b_y[k]));
      chk("b2b_rdy", 32'(a_if.code_ready), 32'd0);
      for (int i = 1; i < 4; i++) begin
        step();
        chk("b2b_hold", 32'(a_if.y), 32'(b2b_y[k]));
        chk("b2b_hold_rdy", 32'(a_if.code_ready), 32'd0);
      end
      step();
      chk("b2b_gap_y", 32'(a_if.y), 32'h00);
      chk("b2b_gap_rdy", 32'(a_if.code_ready), 32'd0);
      step();
      chk("b2b_idle_rdy", 32'(a_if.code_ready), 32'd1);
      chk("b2b_idle_y", 32'(a_if.y), 32'h00);
    end
    a_if.code_valid = 1'b0;

    // Abort: en drops during the second hold cycle of code 6.
    a_if.code = 3'd6; a_if.code_valid = 1'b1;
    step();
    a_if.code_valid = 1'b0;
    chk("abort_y0", 32'(a_if.y), 32'h40);
    step();
    chk("abort_y1", 32'(a_if.y), 32'h40);
    a_if.en = 1'b0;
    #1;
    chk("abort_rdy_now", 32'(a_if.code_ready), 32'd0);
    step();
    chk("abort_y", 32'(a_if.y), 32'h00);
    chk("abort_busy", 32'(a_if.busy), 32'd0);
    chk("abort_yv", 32'(a_if.y_valid), 32'd0);
    chk("abort_rdy", 32'(a_if.code_ready), 32'd0);
    a_if.code_valid = 1'b1;
    step();
    chk("abort_dis_y", 32'(a_if.y), 32'h00);
    chk("abort_dis_rdy", 32'(a_if.code_ready), 32'd0);
    a_if.code_valid = 1'b0;
    a_if.en = 1'b1;
    #1;
    chk("abort_reen_rdy", 32'(a_if.code_ready), 32'd1);

    // Async reset mid-hold clears y before the next edge.
    step();
    a_if.code = 3'd4; a_if.code_valid = 1'b1;
    step();
    a_if.code_valid = 1'b0;
    step();
    chk("arst_pre_y", 32'(a_if.y), 32'h10);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_y", 32'(a_if.y), 32'h00);
    chk("arst_yv", 32'(a_if.y_valid), 32'd0);
    chk("arst_busy", 32'(a_if.busy), 32'd0);
    step();
    rst = 1'b0;
    step();
    chk("arst_after_y", 32'(a_if.y), 32'h00);
    chk("arst_after_busy", 32'(a_if.busy), 32'd0);
    chk("arst_after_rdy", 32'(a_if.code_ready), 32'd1);
    step();
    chk("arst_noreplay_y", 32'(a_if.y), 32'h00);

    // HOLD=1, GAP=0 corner: walk codes 0..7 with valid held.
    b_if.en = 1'b1;
    b_if.code_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      b_if.code = 3'(i);
      step();
      chk("walk_y", 32'(b_if.y), 32'(walk_y[i]));
      chk("walk_yv", 32'(b_if.y_valid), 32'd1);
      step();
      chk("walk_gap_y", 32'(b_if.y), 32'h00);
      chk("walk_rdy", 32'(b_if.code_ready), 32'd1);
    end
    b_if.code_valid = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
